// File: rtl/fma16_pkg.sv
// Shared types and helpers for the fma16 datapath and its scheduler.
// The op word is {roundmode[1:0], mul, add, negp, negz}.
// Rounding modes: 0 nearest-even, 1 toward zero, 2 toward -inf, 3 toward +inf.
package fma16_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RZ  = 2'd1,
        RM_RDN = 2'd2,
        RM_RUP = 2'd3
    } fma16_rm_t;

    typedef struct packed {
        fma16_rm_t roundmode;
        logic      mul;
        logic      add;
        logic      negp;
        logic      negz;
    } fma16_op_t;

    localparam int FLAG_INV = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    localparam logic [15:0] FP_ONE  = 16'h3C00;
    localparam logic [15:0] FP_QNAN = 16'h7E00;

    // Operand classification on the magnitude bits of a half-precision value
    function automatic logic is_nan(input logic [14:0] v);
        return (&v[14:10]) & (|v[9:0]);
    endfunction

    function automatic logic is_snan(input logic [14:0] v);
        return is_nan(v) & ~v[9];
    endfunction

    function automatic logic is_inf(input logic [14:0] v);
        return (&v[14:10]) & ~(|v[9:0]);
    endfunction

    function automatic logic is_zero(input logic [14:0] v);
        return ~(|v);
    endfunction

    // Significand with hidden bit; subnormals have hidden bit 0
    function automatic logic [10:0] signif(input logic [14:0] v);
        return {|v[14:10], v[9:0]};
    endfunction

    // Subnormals share the scale of exponent field 1
    function automatic logic [4:0] exp_adj(input logic [14:0] v);
        return (v[14:10] == 5'd0) ? 5'd1 : v[14:10];
    endfunction

endpackage

// File: rtl/fma16.sv
// Combinational half-precision fused multiply-add: result = +/-(x*y) +/- z.
// mul=0 replaces y with 1.0, add=0 replaces z with a zero of the product's sign.
// The sum is formed exactly on a fixed-point grid (LSB 2^-48) and rounded once.
module fma16
    import fma16_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic [5:0]  op,
    output logic [15:0] result,
    output logic [3:0]  flags
);
    localparam int W = 82;

    fma16_op_t    o;
    logic [15:0]  ye, ze;
    logic         sp, sz, sgn, zsign;
    logic         any_nan, any_snan, invalid, p_inf, z_inf;
    logic [10:0]  mx, my, mz;
    logic [21:0]  mprod;
    logic [5:0]   shp, shz;
    logic [W-1:0] pfx, zfx, mag;
    logic [6:0]   lead, sh, base;
    logic [10:0]  kept;
    logic         rbit, sticky, inexact, inc, tiny, ovf, ovf_inf;
    logic [16:0]  field, rounded;

    assign o  = fma16_op_t'(op);
    assign ye = o.mul ? y : FP_ONE;
    assign ze = o.add ? z : 16'h0000;
    assign sp = x[15] ^ ye[15] ^ o.negp;
    assign sz = o.add ? (z[15] ^ o.negz) : sp;

    assign any_nan  = is_nan(x[14:0]) | is_nan(ye[14:0]) | is_nan(ze[14:0]);
    assign any_snan = is_snan(x[14:0]) | is_snan(ye[14:0]) | is_snan(ze[14:0]);
    assign p_inf    = is_inf(x[14:0]) | is_inf(ye[14:0]);
    assign z_inf    = is_inf(ze[14:0]);
    assign invalid  = (is_inf(x[14:0]) & is_zero(ye[14:0])) | (is_zero(x[14:0]) & is_inf(ye[14:0]))
                    | (p_inf & z_inf & (sp != sz));

    assign mx    = signif(x[14:0]);
    assign my    = signif(ye[14:0]);
    assign mz    = signif(ze[14:0]);
    assign mprod = {11'b0, mx} * {11'b0, my};
    assign shp   = {1'b0, exp_adj(x[14:0])} + {1'b0, exp_adj(ye[14:0])} - 6'd2;
    assign shz   = {1'b0, exp_adj(ze[14:0])} + 6'd23;
    assign pfx   = {60'b0, mprod} << shp;
    assign zfx   = {71'b0, mz} << shz;
    assign zsign = (sp == sz) ? sp : (o.roundmode == RM_RDN);

    // Exact signed-magnitude sum of product and addend
    always_comb begin
        if (sp == sz) begin
            mag = pfx + zfx;
            sgn = sp;
        end else if (pfx >= zfx) begin
            mag = pfx - zfx;
            sgn = sp;
        end else begin
            mag = zfx - pfx;
            sgn = sz;
        end
    end

    // Normalise to 11 significant bits (or the subnormal grid) and round
    always_comb begin
        lead = '0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) lead = 7'(i);
        end
        if (lead >= 7'd34) begin
            sh   = lead - 7'd10;
            base = lead - 7'd34;
        end else begin
            sh   = 7'd24;
            base = '0;
        end
        kept    = 11'(mag >> sh);
        rbit    = mag[sh - 7'd1];
        sticky  = |(mag << (7'd83 - sh));
        inexact = rbit | sticky;
        tiny    = lead < 7'd34;
        case (o.roundmode)
            RM_RNE:  begin inc = rbit & (sticky | kept[0]); ovf_inf = 1'b1; end
            RM_RZ:   begin inc = 1'b0;                      ovf_inf = 1'b0; end
            RM_RDN:  begin inc = sgn & inexact;             ovf_inf = sgn;  end
            default: begin inc = ~sgn & inexact;            ovf_inf = ~sgn; end
        endcase
        // Hidden bit carries into the exponent field, so a rounding carry needs no fix-up
        field   = {base, 10'b0} + {6'b0, kept};
        rounded = field + {16'b0, inc};
        ovf     = rounded >= 17'h07C00;
    end

    // Special-case selection and exception flags
    always_comb begin
        result = {sgn, rounded[14:0]};
        flags  = '0;
        if (any_nan | invalid) begin
            result          = FP_QNAN;
            flags[FLAG_INV] = any_snan | invalid;
        end else if (p_inf) begin
            result = {sp, 15'h7C00};
        end else if (z_inf) begin
            result = {sz, 15'h7C00};
        end else if (mag == '0) begin
            result = {zsign, 15'h0000};
        end else begin
            flags[FLAG_INX] = inexact | ovf;
            flags[FLAG_UNF] = tiny & inexact;
            if (ovf) begin
                flags[FLAG_OVF] = 1'b1;
                result = ovf_inf ? {sgn, 15'h7C00} : {sgn, 15'h7BFF};
            end
        end
    end

endmodule

// File: rtl/fma16_rr_arb.sv
// Round-robin grant over req_valid; the search starts at the pointer, which
// moves one past the winner on every handshake and otherwise holds.
module fma16_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic            handshake,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner
);
    logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
    logic           any_valid;
    int             idx;

    assign any_valid = |req_valid;

    // First valid requester at or after the pointer, wrapping around
    always_comb begin
        winner = rr_ptr_reg;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) winner = IDW'(idx);
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant[gi] = any_valid & (winner == IDW'(gi));
    end

    assign rr_ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

    // Pointer advances past the winner only when a request is accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
        end else if (handshake) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/fma16_sched.sv
// Shares one fma16 among NREQ requesters: round-robin grant into an operand
// register (stage A), fma16 in between, result register (stage B) on the output.
// Define FMA16_SCHED_FLAGS_EN to register and drive the fma16 exception flags.
module fma16_sched
    import fma16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*16-1:0] req_x,
    input  logic [NREQ*16-1:0] req_y,
    input  logic [NREQ*16-1:0] req_z,
    input  logic [NREQ*6-1:0]  req_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [15:0]      resp_result,
    output logic [3:0]       resp_flags,
    output logic [IDW-1:0]   resp_id,
    output logic             busy
);
    logic [15:0]     x_arr [NREQ];
    logic [15:0]     y_arr [NREQ];
    logic [15:0]     z_arr [NREQ];
    logic [5:0]      op_arr [NREQ];
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  winner;
    logic            adv_a, adv_b, hs;
    logic            valid_a_reg, valid_b_reg;
    logic [15:0]     x_a_reg, y_a_reg, z_a_reg;
    logic [5:0]      op_a_reg;
    logic [IDW-1:0]  id_a_reg, id_b_reg;
    logic [15:0]     result_b_reg;
    logic [15:0]     fma_result;
    logic [3:0]      fma_flags;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign x_arr[gi]  = req_x[16*gi +: 16];
        assign y_arr[gi]  = req_y[16*gi +: 16];
        assign z_arr[gi]  = req_z[16*gi +: 16];
        assign op_arr[gi] = req_op[6*gi +: 6];
    end

    assign adv_b     = !valid_b_reg | resp_ready;
    assign adv_a     = !valid_a_reg | adv_b;
    // Ready is held low while reset is asserted so nothing is accepted then
    assign hs        = adv_a & reset & (|req_valid);
    assign req_ready = grant & {NREQ{adv_a & reset}};

    fma16_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .handshake (hs),
        .grant     (grant),
        .winner    (winner)
    );

    fma16 u_fma (
        .x      (x_a_reg),
        .y      (y_a_reg),
        .z      (z_a_reg),
        .op     (op_a_reg),
        .result (fma_result),
        .flags  (fma_flags)
    );

    // Pipeline occupancy and the result/id register; in-flight ops vanish on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_a_reg  <= 1'b0;
            valid_b_reg  <= 1'b0;
            result_b_reg <= '0;
            id_b_reg     <= '0;
        end else begin
            if (adv_a) valid_a_reg <= |req_valid;
            if (adv_b) begin
                valid_b_reg <= valid_a_reg;
                if (valid_a_reg) begin
                    result_b_reg <= fma_result;
                    id_b_reg     <= id_a_reg;
                end
            end
        end
    end

    // Operand register captures the granted request on a handshake only
    always_ff @(posedge clk) begin
        if (hs) begin
            x_a_reg  <= x_arr[winner];
            y_a_reg  <= y_arr[winner];
            z_a_reg  <= z_arr[winner];
            op_a_reg <= op_arr[winner];
            id_a_reg <= winner;
        end
    end

`ifdef FMA16_SCHED_FLAGS_EN
    logic [3:0] flags_b_reg;

    // Flags travel alongside the result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_b_reg <= '0;
        end else if (adv_b && valid_a_reg) begin
            flags_b_reg <= fma_flags;
        end
    end

    assign resp_flags = flags_b_reg;
`else
    logic unused_flags;
    assign unused_flags = ^fma_flags;
    assign resp_flags   = 4'b0000;
`endif

    assign resp_valid  = valid_b_reg;
    assign resp_result = result_b_reg;
    assign resp_id     = id_b_reg;
    assign busy        = valid_a_reg | valid_b_reg;

endmodule

// File: tb/tb_fma16_sched.sv
// Directed bench for fma16_sched: vector table for single ops, then reset with
// ops in flight, round-robin fairness and output backpressure sequences.
module tb_fma16_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

`ifdef FMA16_SCHED_FLAGS_EN
    localparam logic [3:0] FL_OVX = 4'b0101;
    localparam logic [3:0] FL_INV = 4'b1000;
`else
    localparam logic [3:0] FL_OVX = 4'b0000;
    localparam logic [3:0] FL_INV = 4'b0000;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_x, req_y, req_z;
    logic [NREQ*6-1:0] req_op;
    logic              resp_valid, resp_ready;
    logic [15:0]       resp_result;
    logic [3:0]        resp_flags;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    fma16_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_z       (req_z),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .resp_id     (resp_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] x, y, z;
        logic [5:0]  op;
        logic [15:0] res;
        bit          chk_res;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z, input logic [5:0] op);
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
        req_z[16*i +: 16] = z;
        req_op[6*i +: 6]  = op;
    endtask

    logic [15:0] lane_res [4];
    logic [3:0]  bp_valid [11];
    logic [3:0]  bp_ready [11];
    bit          bp_rready [11];
    int          exp_q [$];
    int          pops;
    bit          stale;

    initial begin
        vecs[0] = '{2, 16'h3C00, 16'h4000, 16'h3C00, 6'h0C, 16'h4200, 1'b1, 4'b0000};
        vecs[1] = '{1, 16'h4000, 16'h4000, 16'h3C00, 6'h0D, 16'h4200, 1'b1, 4'b0000};
        vecs[2] = '{0, 16'h4000, 16'h4000, 16'h1234, 6'h08, 16'h4400, 1'b1, 4'b0000};
        vecs[3] = '{3, 16'h3800, 16'h3800, 16'h3400, 6'h0C, 16'h3800, 1'b1, 4'b0000};
        vecs[4] = '{1, 16'h3C00, 16'h0000, 16'h3C00, 6'h04, 16'h4000, 1'b1, 4'b0000};
        vecs[5] = '{0, 16'h4000, 16'h4000, 16'h3C00, 6'h0E, 16'hC200, 1'b1, 4'b0000};
        vecs[6] = '{2, 16'h3C00, 16'h3C00, 16'h3C00, 6'h0D, 16'h0000, 1'b1, 4'b0000};
        vecs[7] = '{3, 16'h7BFF, 16'h7BFF, 16'h0000, 6'h08, 16'h0000, 1'b0, FL_OVX};
        vecs[8] = '{0, 16'h7C00, 16'h4000, 16'h0000, 6'h08, 16'h7C00, 1'b1, 4'b0000};
        vecs[9] = '{1, 16'h7C00, 16'h0000, 16'h0000, 6'h08, 16'h0000, 1'b0, FL_INV};

        reset = 1'b0; req_valid = '1; resp_ready = 1'b1;
        req_x = '0; req_y = '0; req_z = '0; req_op = '0;

        // Reset state, with requests pending to show ready stays low
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_result", 32'(resp_result), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_flags", 32'(resp_flags), 32'd0);
        req_valid = '0;
        reset = 1'b1;

        // Single-op vectors: handshake at edge t, response visible after edge t+1
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            set_lane(vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].op);
            req_valid = 4'(1 << vecs[v].id);
            #1;
            check($sformatf("v%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].id));
            @(negedge clk);
            req_valid = '0;
            check($sformatf("v%0d_early_valid", v), 32'(resp_valid), 32'd0);
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_resp_valid", v), 32'(resp_valid), 32'd1);
            check($sformatf("v%0d_id", v), 32'(resp_id), 32'(vecs[v].id));
            if (vecs[v].chk_res)
                check($sformatf("v%0d_result", v), 32'(resp_result), 32'(vecs[v].res));
            check($sformatf("v%0d_flags", v), 32'(resp_flags), 32'(vecs[v].flags));
            $display("vec %0d: id=%0d x=%h y=%h z=%h op=%h -> result=%h flags=%b",
                     v, resp_id, vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].op, resp_result, resp_flags);
        end

        // Lane operands for the multi-request sequences: x_i * 2
        lane_res = '{16'h4000, 16'h4400, 16'h4600, 16'h4800};
        set_lane(0, 16'h3C00, 16'h4000, 16'h0000, 6'h08);
        set_lane(1, 16'h4000, 16'h4000, 16'h0000, 6'h08);
        set_lane(2, 16'h4200, 16'h4000, 16'h0000, 6'h08);
        set_lane(3, 16'h4400, 16'h4000, 16'h0000, 6'h08);

        // Reset with two ops in flight: both are dropped
        @(negedge clk);
        req_valid = '1; resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("inflight_busy", 32'(busy), 32'd1);
        check("inflight_resp_valid", 32'(resp_valid), 32'd1);
        req_valid = '0; reset = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b1; resp_ready = 1'b1;
        stale = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) stale = 1'b1;
        end
        check("midrst_no_stale", 32'(stale), 32'd0);
        $display("reset: in-flight ops discarded");

        // Fairness: all valid, sink always ready; pointer starts at 0 after reset
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = (k < 6) ? 4'hF : 4'h0;
            #1;
            if (k < 6) check($sformatf("fair%0d_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                check($sformatf("fair%0d_resp_valid", k), 32'(resp_valid), 32'd1);
                check($sformatf("fair%0d_id", k), 32'(resp_id), 32'((k - 2) % 4));
                check($sformatf("fair%0d_result", k), 32'(resp_result), 32'(lane_res[(k - 2) % 4]));
                $display("fair resp: id=%0d result=%h", resp_id, resp_result);
            end
        end

        // Backpressure: pointer now at 2; sink stalls, then releases
        bp_valid  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        bp_rready = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        bp_ready  = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
                      4'b0000, 4'b0000, 4'b0000, 4'b0000};
        pops = 0;
        for (int s = 0; s < 11; s++) begin
            @(negedge clk);
            req_valid  = bp_valid[s];
            resp_ready = bp_rready[s];
            #1;
            check($sformatf("bp%0d_ready", s), 32'(req_ready), 32'(bp_ready[s]));
            for (int b = 0; b < NREQ; b++) begin
                if (bp_ready[s][b]) exp_q.push_back(b);
            end
            if (s >= 2 && s <= 4) begin
                check($sformatf("bp%0d_hold_valid", s), 32'(resp_valid), 32'd1);
                check($sformatf("bp%0d_hold_id", s), 32'(resp_id), 32'd2);
                check($sformatf("bp%0d_hold_result", s), 32'(resp_result), 32'(lane_res[2]));
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("bp%0d_spurious", s), 32'(resp_valid), 32'd0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    pops++;
                    check($sformatf("bp%0d_id", s), 32'(resp_id), 32'(e));
                    check($sformatf("bp%0d_result", s), 32'(resp_result), 32'(lane_res[e]));
                    $display("bp resp: id=%0d result=%h", resp_id, resp_result);
                end
            end
        end
        check("bp_pops", 32'(pops), 32'd4);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("bp_final_valid", 32'(resp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
